// File: rtl/hash_row_stream_arbiter.sv
// hash_row_stream_arbiter
//
// Round-robin arbiter that shares one downstream port between N lanes.
// Each lane sends multi-beat jobs, and the last beat of a job carries delim.
// The granted beat passes through a single registered forward stage.
// Each beat on the output is tagged with the lane it came from.
//
// Configuration macro: HASH_ROW_ARB_JOB_LOCK_EN
//   defined   : the grant is held on one lane until that lane's delim beat.
//   undefined : arbitration runs on every beat, so jobs may interleave.
//               busy_o is tied to 0.
//
// Ports:
//   clk_i, rst_i      clock; asynchronous active-high reset
//   in_valid_i   [N]  per-lane beat valid
//   in_payload_i [N*W] lane i occupies bits [i*W +: W]
//   in_delim_i   [N]  per-lane last-beat-of-job flag
//   in_ready_o   [N]  per-lane accept (one-hot or zero)
//   out_valid_o, out_payload_o, out_delim_o, out_src_o : registered output beat
//   out_ready_i       downstream accept
//   busy_o            registered; high while a job holds the grant
//
// States (only when HASH_ROW_ARB_JOB_LOCK_EN is defined):
//   state     | meaning
//   ST_IDLE   | round-robin scan from rr_q picks the lane to grant
//   ST_LOCKED | owner_q keeps the grant until its delim beat is accepted

module hash_row_stream_arbiter #(
    parameter int N      = 4,
    parameter int N_LOG2 = 2,
    parameter int W      = 64
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [N-1:0]        in_valid_i,
    input  logic [N*W-1:0]      in_payload_i,
    input  logic [N-1:0]        in_delim_i,
    output logic [N-1:0]        in_ready_o,
    output logic                out_valid_o,
    output logic [W-1:0]        out_payload_o,
    output logic                out_delim_o,
    output logic [N_LOG2-1:0]   out_src_o,
    input  logic                out_ready_i,
    output logic                busy_o
);

    logic [N_LOG2-1:0] rr_q, rr_d;
    logic              out_valid_q, out_valid_d;
    logic [W-1:0]      out_payload_q, out_payload_d;
    logic              out_delim_q, out_delim_d;
    logic [N_LOG2-1:0] out_src_q, out_src_d;

    logic              stage_ready;
    logic              grant_valid;
    logic [N_LOG2-1:0] grant_lane;
    logic [N_LOG2-1:0] scan_idx;
    logic              accept;
    logic [W-1:0]      sel_payload;
    logic              sel_delim;

`ifdef HASH_ROW_ARB_JOB_LOCK_EN
    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_t;

    state_t            state_q, state_d;
    logic [N_LOG2-1:0] owner_q, owner_d;
`endif

    // The output stage can take a new beat when it is empty or being drained.
    assign stage_ready = !out_valid_q || out_ready_i;

    // Lane selection. The scan starts at rr_q and wraps naturally in N_LOG2 bits.
    // While locked, the owner is the only candidate, even if it has a bubble.
    always_comb begin
        grant_valid = 1'b0;
        grant_lane  = '0;
        scan_idx    = '0;
        for (int k = 0; k < N; k++) begin
            scan_idx = rr_q + N_LOG2'(k);
            if (!grant_valid && in_valid_i[scan_idx]) begin
                grant_valid = 1'b1;
                grant_lane  = scan_idx;
            end
        end
`ifdef HASH_ROW_ARB_JOB_LOCK_EN
        if (state_q == ST_LOCKED) begin
            grant_lane  = owner_q;
            grant_valid = in_valid_i[owner_q];
        end
`endif
    end

    assign accept = grant_valid && stage_ready;

    always_comb begin
        sel_payload = '0;
        sel_delim   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (grant_lane == N_LOG2'(i)) begin
                sel_payload = in_payload_i[i*W +: W];
                sel_delim   = in_delim_i[i];
            end
        end
    end

    // The ready signal is driven from the grant only, never from the payload.
    always_comb begin
        in_ready_o = '0;
        if (accept) begin
            in_ready_o[grant_lane] = 1'b1;
        end
    end

    always_comb begin
        rr_d          = rr_q;
        out_valid_d   = out_valid_q;
        out_payload_d = out_payload_q;
        out_delim_d   = out_delim_q;
        out_src_d     = out_src_q;

        if (accept) begin
            out_valid_d   = 1'b1;
            out_payload_d = sel_payload;
            out_delim_d   = sel_delim;
            out_src_d     = grant_lane;
        end else if (out_ready_i) begin
            out_valid_d   = 1'b0;
        end

`ifdef HASH_ROW_ARB_JOB_LOCK_EN
        state_d = state_q;
        owner_d = owner_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (sel_delim) begin
                        rr_d = grant_lane + N_LOG2'(1);
                    end else begin
                        state_d = ST_LOCKED;
                        owner_d = grant_lane;
                    end
                end
            end
            ST_LOCKED: begin
                if (accept && sel_delim) begin
                    state_d = ST_IDLE;
                    rr_d    = owner_q + N_LOG2'(1);
                end
            end
        endcase
`else
        if (accept) begin
            rr_d = grant_lane + N_LOG2'(1);
        end
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q          <= '0;
            out_valid_q   <= 1'b0;
            out_payload_q <= '0;
            out_delim_q   <= 1'b0;
            out_src_q     <= '0;
        end else begin
            rr_q          <= rr_d;
            out_valid_q   <= out_valid_d;
            out_payload_q <= out_payload_d;
            out_delim_q   <= out_delim_d;
            out_src_q     <= out_src_d;
        end
    end

`ifdef HASH_ROW_ARB_JOB_LOCK_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    assign busy_o = (state_q == ST_LOCKED);
`else
    assign busy_o = 1'b0;
`endif

    assign out_valid_o   = out_valid_q;
    assign out_payload_o = out_payload_q;
    assign out_delim_o   = out_delim_q;
    assign out_src_o     = out_src_q;

endmodule
